// File: rtl/microwave_pkg.sv
// Shared types and helpers for the microwave controller: keypad geometry,
// BCD digit width, key-entry FSM states and the one-hot keypad decode helpers.
package microwave_pkg;

   localparam int KEY_W   = 10;
   localparam int DIGIT_W = 4;

   typedef enum logic [2:0] {
      IDLE,
      PRESS,
      HELD,
      RELEASE,
      WAIT_REL
   } key_state_t;

   // Exactly one key down; zero keys and chords are both rejected.
   function automatic logic is_onehot(input logic [KEY_W-1:0] code);
      return (code != '0) && ((code & (code - KEY_W'(1))) == '0);
   endfunction

   function automatic logic [DIGIT_W-1:0] onehot_to_bcd(input logic [KEY_W-1:0] code);
      logic [DIGIT_W-1:0] digit;
      digit = '0;
      for (int k = 0; k < KEY_W; k++) begin
         if (code[k]) digit = DIGIT_W'(k);
      end
      return digit;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Keypad synchroniser and press/release debouncer. Raises accept for one cycle
// when a single key has been stable for DEBOUNCE cycles; code holds that key.
module key_debounce
   import microwave_pkg::*;
#(
   parameter int DEBOUNCE = 3,
   parameter int CNT_W    = 4
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic [KEY_W-1:0] keypad,
   output logic             accept,
   output logic [KEY_W-1:0] code
);

   localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEBOUNCE);

   logic [KEY_W-1:0] sync1;
   logic [KEY_W-1:0] sync2;
   logic [KEY_W-1:0] code_next;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;
   logic [CNT_W-1:0] cnt_inc;
   key_state_t       state;
   key_state_t       state_next;

   // The raw keypad is asynchronous, so it crosses a two-flop synchroniser first.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= keypad;
         sync2 <= sync1;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state <= WAIT_REL;
         cnt   <= '0;
         code  <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         code  <= code_next;
      end
   end

   // Starting in WAIT_REL means a key held through reset must be released before use.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      code_next  = code;
      accept     = 1'b0;
      cnt_inc    = (cnt == DEB_MAX) ? cnt : cnt + CNT_W'(1);

      case (state)
         IDLE: begin
            if (is_onehot(sync2)) begin
               state_next = PRESS;
               code_next  = sync2;
               cnt_next   = CNT_W'(1);
            end else begin
               cnt_next = '0;
            end
         end

         PRESS: begin
            if (sync2 == code) begin
               cnt_next = cnt_inc;
               if (cnt_inc == DEB_MAX) begin
                  state_next = HELD;
                  accept     = 1'b1;
               end
            end else begin
               state_next = IDLE;
               cnt_next   = '0;
            end
         end

         HELD: begin
            if (sync2 != code) begin
               state_next = RELEASE;
               cnt_next   = (sync2 == '0) ? CNT_W'(1) : '0;
            end
         end

         RELEASE, WAIT_REL: begin
            if (sync2 == '0) begin
               cnt_next = cnt_inc;
               if (cnt_inc == DEB_MAX) state_next = IDLE;
            end else begin
               cnt_next = '0;
            end
         end

         default: begin
            state_next = WAIT_REL;
            cnt_next   = '0;
         end
      endcase
   end

endmodule

// File: rtl/keypad_entry.sv
// Microwave time-entry stage: debounced keypad digits shift into a three-digit
// BCD register (mins, sec_tens, sec_ones), gated by the run lock and user clear.
module keypad_entry
   import microwave_pkg::*;
#(
   parameter int DEBOUNCE = 3,
   parameter int CNT_W    = 4
) (
   input  logic               clock,
   input  logic               resetn,
   input  logic [KEY_W-1:0]   keypad,
   input  logic               clearn,
   input  logic               lockn,
   output logic [DIGIT_W-1:0] mins,
   output logic [DIGIT_W-1:0] sec_tens,
   output logic [DIGIT_W-1:0] sec_ones,
   output logic               key_strobe,
   output logic [DIGIT_W-1:0] key_digit,
   output logic               entry_nz
);

   logic               accept;
   logic [KEY_W-1:0]   held_code;
   logic [DIGIT_W-1:0] new_digit;
   logic [DIGIT_W-1:0] mins_next;
   logic [DIGIT_W-1:0] tens_next;
   logic [DIGIT_W-1:0] ones_next;
   logic [DIGIT_W-1:0] digit_next;
   logic               strobe_next;
   logic               nz_next;

   key_debounce #(
      .DEBOUNCE (DEBOUNCE),
      .CNT_W    (CNT_W)
   ) u_debounce (
      .clock  (clock),
      .resetn (resetn),
      .keypad (keypad),
      .accept (accept),
      .code   (held_code)
   );

   assign new_digit = onehot_to_bcd(held_code);

   // Clear wins over a simultaneous accept; a locked accept is swallowed silently.
   always_comb begin
      mins_next   = mins;
      tens_next   = sec_tens;
      ones_next   = sec_ones;
      digit_next  = key_digit;
      strobe_next = 1'b0;

      if (!clearn) begin
         mins_next = '0;
         tens_next = '0;
         ones_next = '0;
      end else if (accept && lockn) begin
         mins_next   = sec_tens;
         tens_next   = sec_ones;
         ones_next   = new_digit;
         digit_next  = new_digit;
         strobe_next = 1'b1;
      end

      nz_next = (mins_next != '0) || (tens_next != '0) || (ones_next != '0);
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         mins       <= '0;
         sec_tens   <= '0;
         sec_ones   <= '0;
         key_digit  <= '0;
         key_strobe <= 1'b0;
         entry_nz   <= 1'b0;
      end else begin
         mins       <= mins_next;
         sec_tens   <= tens_next;
         sec_ones   <= ones_next;
         key_digit  <= digit_next;
         key_strobe <= strobe_next;
         entry_nz   <= nz_next;
      end
   end

endmodule
